// File: rtl/reg_file_en.sv
// Register file with bit-masked write port, two registered read ports with
// same-cycle write bypass, per-entry valid flags and a multi-cycle clear sweep.
module reg_file_en #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [WIDTH-1:0]  wr_mask,
    output logic              wr_ack,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_a,
    output logic [WIDTH-1:0]  rd_data_b,
    output logic              rd_valid_a,
    output logic              rd_valid_b,
    input  logic              clr,
    output logic              busy
);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              busy_q, busy_d;
    logic              wr_ack_q, wr_ack_d;
    logic [WIDTH-1:0]  rd_data_a_q, rd_data_a_d;
    logic [WIDTH-1:0]  rd_data_b_q, rd_data_b_d;
    logic              rd_valid_a_q, rd_valid_a_d;
    logic              rd_valid_b_q, rd_valid_b_d;
    logic [WIDTH-1:0]  entry_q [DEPTH];
    logic [WIDTH-1:0]  entry_d [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;

    logic              wr_base;
    logic              wr_accept;
    logic [DEPTH-1:0]  wr_sel;
    logic [DEPTH-1:0]  rd_sel_a;
    logic [DEPTH-1:0]  rd_sel_b;
    logic [DEPTH-1:0]  sweep_sel;
    logic [WIDTH-1:0]  wr_cur;
    logic [WIDTH-1:0]  wr_merged;

    assign wr_base = wr_en & ~busy_q & ~clr;

    // One-hot decodes; an address beyond DEPTH-1 matches no entry, which
    // rejects out-of-range writes and makes out-of-range reads return 0/0.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_decode
            assign wr_sel[gi]    = wr_base && (wr_addr == ADDR_W'(gi));
            assign rd_sel_a[gi]  = (rd_addr_a == ADDR_W'(gi));
            assign rd_sel_b[gi]  = (rd_addr_b == ADDR_W'(gi));
            assign sweep_sel[gi] = (state_q == SWEEP) && (ptr_q == ADDR_W'(gi));
        end
    endgenerate

    assign wr_accept = |wr_sel;
    assign wr_merged = (wr_cur & ~wr_mask) | (wr_data & wr_mask);

    always_comb begin
        wr_cur       = '0;
        rd_data_a_d  = '0;
        rd_data_b_d  = '0;
        rd_valid_a_d = 1'b0;
        rd_valid_b_d = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_sel[i]) begin
                wr_cur = entry_q[i];
            end
            if (rd_sel_a[i]) begin
                rd_data_a_d  = entry_q[i];
                rd_valid_a_d = valid_q[i];
            end
            if (rd_sel_b[i]) begin
                rd_data_b_d  = entry_q[i];
                rd_valid_b_d = valid_q[i];
            end
        end
        // Bypass only forwards writes; sweep clears are seen one cycle later.
        if (wr_accept && (rd_addr_a == wr_addr)) begin
            rd_data_a_d  = wr_merged;
            rd_valid_a_d = 1'b1;
        end
        if (wr_accept && (rd_addr_b == wr_addr)) begin
            rd_data_b_d  = wr_merged;
            rd_valid_b_d = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_d[i] = entry_q[i];
            valid_d[i] = valid_q[i];
            if (wr_sel[i]) begin
                entry_d[i] = wr_merged;
                valid_d[i] = 1'b1;
            end else if (sweep_sel[i]) begin
                entry_d[i] = '0;
                valid_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        wr_ack_d = wr_accept;
        case (state_q)
            IDLE: begin
                if (clr) begin
                    state_d = SWEEP;
                    ptr_d   = '0;
                end
            end
            SWEEP: begin
                if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                ptr_d   = '0;
            end
        endcase
        busy_d = (state_d == SWEEP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            busy_q       <= 1'b0;
            wr_ack_q     <= 1'b0;
            rd_data_a_q  <= '0;
            rd_data_b_q  <= '0;
            rd_valid_a_q <= 1'b0;
            rd_valid_b_q <= 1'b0;
            valid_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            busy_q       <= busy_d;
            wr_ack_q     <= wr_ack_d;
            rd_data_a_q  <= rd_data_a_d;
            rd_data_b_q  <= rd_data_b_d;
            rd_valid_a_q <= rd_valid_a_d;
            rd_valid_b_q <= rd_valid_b_d;
            valid_q      <= valid_d;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
        end
    end

    assign wr_ack     = wr_ack_q;
    assign busy       = busy_q;
    assign rd_data_a  = rd_data_a_q;
    assign rd_data_b  = rd_data_b_q;
    assign rd_valid_a = rd_valid_a_q;
    assign rd_valid_b = rd_valid_b_q;

endmodule

// File: tb/tb_reg_file_en.sv
// Bench for reg_file_en (WIDTH=8, DEPTH=6): directed scenarios plus random
// traffic, all checked against an array-based reference model.
module tb_reg_file_en;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 6;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic [WIDTH-1:0]  wr_mask;
    logic              wr_ack;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [WIDTH-1:0]  rd_data_a;
    logic [WIDTH-1:0]  rd_data_b;
    logic              rd_valid_a;
    logic              rd_valid_b;
    logic              clr;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [WIDTH-1:0] m_mem [DEPTH];
    bit               m_vld [DEPTH];
    bit               m_sweep;
    int               m_ptr;
    logic [WIDTH-1:0] exp_rd_data_a, exp_rd_data_b;
    bit               exp_rd_valid_a, exp_rd_valid_b, exp_wr_ack, exp_busy;

    reg_file_en #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
        .wr_ack(wr_ack),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .rd_valid_a(rd_valid_a), .rd_valid_b(rd_valid_b),
        .clr(clr), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = '0;
            m_vld[i] = 1'b0;
        end
        m_sweep = 1'b0;
        m_ptr = 0;
        exp_rd_data_a = '0; exp_rd_data_b = '0;
        exp_rd_valid_a = 1'b0; exp_rd_valid_b = 1'b0;
        exp_wr_ack = 1'b0; exp_busy = 1'b0;
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_mask = '0;
        rd_addr_a = '0; rd_addr_b = '0; clr = 1'b0;
    endtask

    // Predict the outputs of the coming edge from the current inputs, then
    // advance one clock and return 1 time unit after the rising edge.
    task automatic step();
        int wa, ra, rb;
        bit accept;
        logic [WIDTH-1:0] merged;
        wa = int'(wr_addr); ra = int'(rd_addr_a); rb = int'(rd_addr_b);
        accept = wr_en && !m_sweep && !clr && (wa < DEPTH);
        merged = '0;
        if (wa < DEPTH) merged = (m_mem[wa] & ~wr_mask) | (wr_data & wr_mask);
        if (ra >= DEPTH) begin
            exp_rd_data_a = '0; exp_rd_valid_a = 1'b0;
        end else if (accept && ra == wa) begin
            exp_rd_data_a = merged; exp_rd_valid_a = 1'b1;
        end else begin
            exp_rd_data_a = m_mem[ra]; exp_rd_valid_a = m_vld[ra];
        end
        if (rb >= DEPTH) begin
            exp_rd_data_b = '0; exp_rd_valid_b = 1'b0;
        end else if (accept && rb == wa) begin
            exp_rd_data_b = merged; exp_rd_valid_b = 1'b1;
        end else begin
            exp_rd_data_b = m_mem[rb]; exp_rd_valid_b = m_vld[rb];
        end
        if (accept) begin
            m_mem[wa] = merged;
            m_vld[wa] = 1'b1;
        end
        if (m_sweep) begin
            m_mem[m_ptr] = '0;
            m_vld[m_ptr] = 1'b0;
            if (m_ptr == DEPTH - 1) begin
                m_sweep = 1'b0;
                m_ptr = 0;
            end else begin
                m_ptr++;
            end
        end else if (clr) begin
            m_sweep = 1'b1;
            m_ptr = 0;
        end
        exp_wr_ack = accept;
        exp_busy = m_sweep;
        @(posedge clk);
        #1;
        $display("txn t=%0t we=%0b wa=%0d wd=%02h wm=%02h clr=%0b ra=%0d rb=%0d | ack=%0b busy=%0b a=%02h/%0b b=%02h/%0b",
                 $time, wr_en, wr_addr, wr_data, wr_mask, clr, rd_addr_a, rd_addr_b,
                 wr_ack, busy, rd_data_a, rd_valid_a, rd_data_b, rd_valid_b);
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #1;
        checks++;
        if (rd_data_a !== 0 || rd_data_b !== 0 || rd_valid_a !== 0 || rd_valid_b !== 0 ||
            wr_ack !== 0 || busy !== 0) begin
            failures++;
            $display("FAIL reset_outputs: got a=%h/%b b=%h/%b ack=%b busy=%b, want all 0",
                     rd_data_a, rd_valid_a, rd_data_b, rd_valid_b, wr_ack, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int a = 0; a < 8; a++) begin
            rd_addr_a = ADDR_W'(a);
            rd_addr_b = ADDR_W'(7 - a);
            step();
            checks++;
            if (rd_data_a !== 0 || rd_valid_a !== 0 || rd_data_b !== 0 || rd_valid_b !== 0 ||
                wr_ack !== 0 || busy !== 0) begin
                failures++;
                $display("FAIL reset_read addr=%0d: got a=%h/%b b=%h/%b ack=%b busy=%b, want 0",
                         a, rd_data_a, rd_valid_a, rd_data_b, rd_valid_b, wr_ack, busy);
            end
        end
    endtask

    task automatic test_masked_merge();
        idle_inputs();
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hA5; wr_mask = 8'hFF; rd_addr_a = 3'd3;
        step();
        checks++;
        if (wr_ack !== 1'b1 || rd_data_a !== 8'hA5 || rd_valid_a !== 1'b1) begin
            failures++;
            $display("FAIL merge_first: got ack=%b a=%h/%b, want 1 a5/1", wr_ack, rd_data_a, rd_valid_a);
        end
        wr_data = 8'h0F; wr_mask = 8'h0F;
        step();
        checks++;
        if (wr_ack !== 1'b1 || rd_data_a !== 8'hAF || rd_valid_a !== 1'b1) begin
            failures++;
            $display("FAIL merge_second: got ack=%b a=%h/%b, want 1 af/1", wr_ack, rd_data_a, rd_valid_a);
        end
        wr_en = 1'b0;
        step();
        checks++;
        if (wr_ack !== 1'b0 || rd_data_a !== 8'hAF || rd_valid_a !== 1'b1) begin
            failures++;
            $display("FAIL merge_readback: got ack=%b a=%h/%b, want 0 af/1", wr_ack, rd_data_a, rd_valid_a);
        end
    endtask

    task automatic test_bypass();
        idle_inputs();
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 8'h3C; wr_mask = 8'hFF;
        rd_addr_a = 3'd5; rd_addr_b = 3'd4;
        step();
        checks++;
        if (rd_data_a !== 8'h3C || rd_valid_a !== 1'b1) begin
            failures++;
            $display("FAIL bypass_a: got %h/%b, want 3c/1", rd_data_a, rd_valid_a);
        end
        checks++;
        if (rd_data_b !== exp_rd_data_b || rd_valid_b !== exp_rd_valid_b || wr_ack !== 1'b1) begin
            failures++;
            $display("FAIL bypass_b: got %h/%b ack=%b, want %h/%b ack=1",
                     rd_data_b, rd_valid_b, wr_ack, exp_rd_data_b, exp_rd_valid_b);
        end
        wr_en = 1'b0;
        step();
    endtask

    task automatic fill_all();
        idle_inputs();
        for (int i = 0; i < DEPTH; i++) begin
            wr_en = 1'b1; wr_addr = ADDR_W'(i);
            wr_data = WIDTH'($urandom) | 8'h01; wr_mask = 8'hFF;
            step();
            checks++;
            if (wr_ack !== 1'b1) begin
                failures++;
                $display("FAIL fill_ack addr=%0d: got %b, want 1", i, wr_ack);
            end
        end
        wr_en = 1'b0;
    endtask

    task automatic test_clear();
        int n_busy;
        int n_ack;
        fill_all();
        clr = 1'b1; wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h77; wr_mask = 8'hFF;
        step();
        clr = 1'b0;
        checks++;
        if (wr_ack !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL clear_start: got ack=%b busy=%b, want 0 1", wr_ack, busy);
        end
        n_busy = (busy === 1'b1) ? 1 : 0;
        n_ack = 0;
        for (int g = 0; g < 3 * DEPTH; g++) begin
            step();
            if (wr_ack === 1'b1) n_ack++;
            if (busy === 1'b1) n_busy++;
            else break;
        end
        checks++;
        if (n_busy != DEPTH || n_ack != 0) begin
            failures++;
            $display("FAIL clear_busy_len: got busy_cycles=%0d acks=%0d, want %0d 0", n_busy, n_ack, DEPTH);
        end
        wr_en = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr_a = ADDR_W'(a); rd_addr_b = ADDR_W'(DEPTH - 1 - a);
            step();
            checks++;
            if (rd_data_a !== 0 || rd_valid_a !== 0 || rd_data_b !== 0 || rd_valid_b !== 0) begin
                failures++;
                $display("FAIL clear_read addr=%0d: got a=%h/%b b=%h/%b, want 0/0",
                         a, rd_data_a, rd_valid_a, rd_data_b, rd_valid_b);
            end
        end
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h77; wr_mask = 8'hFF;
        step();
        wr_en = 1'b0;
        checks++;
        if (wr_ack !== 1'b1) begin
            failures++;
            $display("FAIL clear_after_write: got ack=%b, want 1", wr_ack);
        end
    endtask

    task automatic test_out_of_range();
        idle_inputs();
        wr_en = 1'b1; wr_addr = 3'd7; wr_data = 8'hFF; wr_mask = 8'hFF;
        rd_addr_a = 3'd6; rd_addr_b = 3'd2;
        step();
        wr_en = 1'b0;
        checks++;
        if (wr_ack !== 1'b0 || rd_data_a !== 0 || rd_valid_a !== 0) begin
            failures++;
            $display("FAIL oor_access: got ack=%b a=%h/%b, want 0 00/0", wr_ack, rd_data_a, rd_valid_a);
        end
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr_a = ADDR_W'(a); rd_addr_b = ADDR_W'(a);
            step();
            checks++;
            if (rd_data_a !== exp_rd_data_a || rd_valid_a !== exp_rd_valid_a ||
                rd_data_b !== exp_rd_data_b || rd_valid_b !== exp_rd_valid_b) begin
                failures++;
                $display("FAIL oor_storage addr=%0d: got a=%h/%b b=%h/%b, want %h/%b",
                         a, rd_data_a, rd_valid_a, rd_data_b, rd_valid_b, exp_rd_data_a, exp_rd_valid_a);
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        fill_all();
        rd_addr_a = 3'd4; rd_addr_b = 3'd5;
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int k = 0; k < 3; k++) step();
        checks++;
        if (busy !== 1'b1 || rd_data_a === 0 || rd_data_b === 0 ||
            rd_data_a !== exp_rd_data_a || rd_data_b !== exp_rd_data_b) begin
            failures++;
            $display("FAIL mid_sweep_pre: got busy=%b a=%h b=%h, want 1 %h %h",
                     busy, rd_data_a, rd_data_b, exp_rd_data_a, exp_rd_data_b);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 0 || wr_ack !== 0 || rd_data_a !== 0 || rd_valid_a !== 0 ||
            rd_data_b !== 0 || rd_valid_b !== 0) begin
            failures++;
            $display("FAIL mid_sweep_rst: got busy=%b ack=%b a=%h/%b b=%h/%b, want all 0",
                     busy, wr_ack, rd_data_a, rd_valid_a, rd_data_b, rd_valid_b);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step();
        checks++;
        if (busy !== 0 || rd_data_a !== 0 || rd_valid_a !== 0 || rd_data_b !== 0 || rd_valid_b !== 0) begin
            failures++;
            $display("FAIL mid_sweep_after: got busy=%b a=%h/%b b=%h/%b, want 0 and 0/0",
                     busy, rd_data_a, rd_valid_a, rd_data_b, rd_valid_b);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            wr_en     = ($urandom_range(0, 3) != 0);
            wr_addr   = ADDR_W'($urandom);
            wr_data   = WIDTH'($urandom);
            wr_mask   = WIDTH'($urandom);
            rd_addr_a = ADDR_W'($urandom);
            rd_addr_b = ($urandom_range(0, 1) == 1) ? wr_addr : ADDR_W'($urandom);
            clr       = ($urandom_range(0, 39) == 0);
            step();
            checks++;
            if (wr_ack !== exp_wr_ack || busy !== exp_busy ||
                rd_data_a !== exp_rd_data_a || rd_valid_a !== exp_rd_valid_a ||
                rd_data_b !== exp_rd_data_b || rd_valid_b !== exp_rd_valid_b) begin
                failures++;
                $display("FAIL random n=%0d: got ack=%b busy=%b a=%h/%b b=%h/%b, want ack=%b busy=%b a=%h/%b b=%h/%b",
                         n, wr_ack, busy, rd_data_a, rd_valid_a, rd_data_b, rd_valid_b,
                         exp_wr_ack, exp_busy, exp_rd_data_a, exp_rd_valid_a, exp_rd_data_b, exp_rd_valid_b);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_masked_merge();
        test_bypass();
        test_clear();
        test_out_of_range();
        test_reset_mid_sweep();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
